// File: rtl/lcd_timebase_gen.sv
// Microsecond timebase for LCD controllers: programmable prescaler producing a
// tick pulse and a square wave, plus a tick-counting delay engine.
module lcd_timebase_gen #(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 99,
  parameter int DLY_W       = 16,
  parameter bit SYNC_START  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [DIV_W-1:0] div_val,
  output logic             us_tick,
  output logic             us_clk,
  input  logic             dly_start,
  input  logic [DLY_W-1:0] dly_len,
  output logic             dly_busy,
  output logic             dly_done
);

  localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_q;
  logic [DLY_W-1:0] rem;
  logic             term;
  logic             accept;

  assign term   = en && (cnt == div_q);
  assign accept = (state == IDLE) && dly_start && (dly_len != '0);

  // Prescaler: the divisor is reloaded only at a wrap so a period never gets cut short.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      div_q   <= DEF_DIV;
      us_clk  <= 1'b0;
      us_tick <= 1'b0;
    end else begin
      us_tick <= term;
      if (term) begin
        cnt    <= '0;
        div_q  <= div_val;
        us_clk <= ~us_clk;
      end else if (en) begin
        cnt <= cnt + DIV_W'(1);
      end
      if (SYNC_START && accept) begin
        cnt <= '0;
      end
    end
  end

  // Delay engine: counts prescaler wraps; outputs are registered with the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      rem      <= '0;
      dly_busy <= 1'b0;
      dly_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (dly_start) begin
            if (dly_len != '0) begin
              state    <= RUN;
              rem      <= dly_len;
              dly_busy <= 1'b1;
            end else begin
              state    <= DONE;
              dly_done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (term) begin
            if (rem == DLY_W'(1)) begin
              state    <= DONE;
              rem      <= '0;
              dly_busy <= 1'b0;
              dly_done <= 1'b1;
            end else begin
              rem <= rem - DLY_W'(1);
            end
          end
        end
        DONE: begin
          state    <= IDLE;
          dly_done <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          dly_busy <= 1'b0;
          dly_done <= 1'b0;
        end
      endcase
    end
  end

endmodule
